// File: rtl/vm_pkg.sv
// Shared coin codes, coin values and dispenser state encoding.
// Used by the vending machine, the board coin encoder and the change return path.
package vm_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  localparam logic [5:0] VAL_5  = 6'd5;
  localparam logic [5:0] VAL_10 = 6'd10;
  localparam logic [5:0] VAL_20 = 6'd20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_PULSE,
    ST_GAP,
    ST_DONE
  } disp_state_t;

  function automatic logic [5:0] coin_value(input logic [1:0] code);
    logic [5:0] v;
    unique case (code)
      COIN_5:  v = VAL_5;
      COIN_10: v = VAL_10;
      COIN_20: v = VAL_20;
      default: v = 6'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_pulse_timer.sv
// Loadable down-counter timing both the eject pulse and the inter-coin gap.
// Expire is high whenever the count has reached zero.
module coin_pulse_timer #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_count,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change return path: pays a change amount as a timed greedy sequence of coins
// while tracking per-denomination inventory and reporting any shortfall.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int PULSE_CYCLES = 1,
  parameter int GAP_CYCLES   = 1,
  parameter int CNT_W        = 4,
  parameter int INIT_20      = 8,
  parameter int INIT_10      = 8,
  parameter int INIT_5       = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [5:0]       i_change,
  input  logic             i_refill,
  output logic [1:0]       o_coin_out,
  output logic             o_eject,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_short,
  output logic [5:0]       o_remaining,
  output logic [CNT_W-1:0] o_inv_20,
  output logic [CNT_W-1:0] o_inv_10,
  output logic [CNT_W-1:0] o_inv_5
);

  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ?
                        PULSE_CYCLES : GAP_CYCLES;
  localparam int TW = $clog2(MAXC) + 1;
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);

  disp_state_t r_state;
  disp_state_t w_next;

  logic [5:0]       r_rem;
  logic [1:0]       r_coin;
  logic             r_short;
  logic [5:0]       r_remaining;
  logic [CNT_W-1:0] r_inv_20;
  logic [CNT_W-1:0] r_inv_10;
  logic [CNT_W-1:0] r_inv_5;

  logic [1:0]    w_sel;
  logic          w_accept;
  logic          w_take;
  logic          w_finish;
  logic          w_tload;
  logic [TW-1:0] w_tval;
  logic          w_tcount;
  logic          w_expire;
  logic          w_refill;

  coin_pulse_timer #(
    .W(TW)
  ) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_tload),
    .i_load_val (w_tval),
    .i_count    (w_tcount),
    .o_expire   (w_expire)
  );

  // Greedy pick: largest coin that fits and is still in stock.
  always_comb begin
    w_sel = COIN_NONE;
    if ((r_rem >= VAL_20) && (r_inv_20 != '0)) begin
      w_sel = COIN_20;
    end else if ((r_rem >= VAL_10) && (r_inv_10 != '0)) begin
      w_sel = COIN_10;
    end else if ((r_rem >= VAL_5) && (r_inv_5 != '0)) begin
      w_sel = COIN_5;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_take   = 1'b0;
    w_finish = 1'b0;
    w_tload  = 1'b0;
    w_tval   = PULSE_LD;
    w_tcount = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start && !i_refill) begin
          w_accept = 1'b1;
          w_next   = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (w_sel != COIN_NONE) begin
          w_take  = 1'b1;
          w_tload = 1'b1;
          w_tval  = PULSE_LD;
          w_next  = ST_PULSE;
        end else begin
          w_finish = 1'b1;
          w_next   = ST_DONE;
        end
      end
      ST_PULSE: begin
        if (w_expire) begin
          w_tload = 1'b1;
          w_tval  = GAP_LD;
          w_next  = ST_GAP;
        end else begin
          w_tcount = 1'b1;
        end
      end
      ST_GAP: begin
        if (w_expire) begin
          w_next = ST_SELECT;
        end else begin
          w_tcount = 1'b1;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rem       <= '0;
      r_coin      <= COIN_NONE;
      r_short     <= 1'b0;
      r_remaining <= '0;
    end else begin
      if (w_accept) begin
        r_rem       <= i_change;
        r_short     <= 1'b0;
        r_remaining <= '0;
      end
      if (w_take) begin
        r_rem  <= r_rem - coin_value(w_sel);
        r_coin <= w_sel;
      end
      if (w_finish) begin
        r_short     <= (r_rem != '0);
        r_remaining <= r_rem;
      end
    end
  end

  assign w_refill = (r_state == ST_IDLE) && i_refill;

  // Only a successful pick decrements, so counts never pass below zero.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_inv_20 <= CNT_W'(INIT_20);
      r_inv_10 <= CNT_W'(INIT_10);
      r_inv_5  <= CNT_W'(INIT_5);
    end else if (w_refill) begin
      r_inv_20 <= CNT_W'(INIT_20);
      r_inv_10 <= CNT_W'(INIT_10);
      r_inv_5  <= CNT_W'(INIT_5);
    end else if (w_take) begin
      unique case (w_sel)
        COIN_20: r_inv_20 <= r_inv_20 - 1'b1;
        COIN_10: r_inv_10 <= r_inv_10 - 1'b1;
        COIN_5:  r_inv_5  <= r_inv_5 - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_eject     = (r_state == ST_PULSE);
  assign o_coin_out  = o_eject ? r_coin : COIN_NONE;
  assign o_done      = (r_state == ST_DONE);
  assign o_short     = r_short;
  assign o_remaining = r_remaining;
  assign o_inv_20    = r_inv_20;
  assign o_inv_10    = r_inv_10;
  assign o_inv_5     = r_inv_5;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a fast instance (1/1 timing) and a slow one (3/2),
// each checked cycle by cycle against a greedy payout model with coin timing.
module tb_change_dispenser;

  logic       clk;
  logic [1:0] rst;
  logic [1:0] start;
  logic [1:0] refill;
  logic [5:0] chg;

  logic [1:0] coin_a, coin_b;
  logic       ej_a, ej_b, bsy_a, bsy_b, dn_a, dn_b, sh_a, sh_b;
  logic [5:0] rm_a, rm_b;
  logic [3:0] i20_a, i10_a, i5_a, i20_b, i10_b, i5_b;

  int         sel;
  logic [1:0] o_coin;
  logic       o_ej, o_bsy, o_dn, o_sh;
  logic [5:0] o_rm;
  logic [3:0] o_i20, o_i10, o_i5;

  int tests;
  int fails;
  int inv[2][3];
  int pc[2];
  int gc[2];

  change_dispenser u_fast (
    .i_clk(clk), .i_reset(rst[0]), .i_start(start[0]),
    .i_change(chg), .i_refill(refill[0]),
    .o_coin_out(coin_a), .o_eject(ej_a), .o_busy(bsy_a),
    .o_done(dn_a), .o_short(sh_a), .o_remaining(rm_a),
    .o_inv_20(i20_a), .o_inv_10(i10_a), .o_inv_5(i5_a)
  );

  change_dispenser #(
    .PULSE_CYCLES(3), .GAP_CYCLES(2)
  ) u_slow (
    .i_clk(clk), .i_reset(rst[1]), .i_start(start[1]),
    .i_change(chg), .i_refill(refill[1]),
    .o_coin_out(coin_b), .o_eject(ej_b), .o_busy(bsy_b),
    .o_done(dn_b), .o_short(sh_b), .o_remaining(rm_b),
    .o_inv_20(i20_b), .o_inv_10(i10_b), .o_inv_5(i5_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (sel == 1) begin
      o_coin = coin_b; o_ej = ej_b; o_bsy = bsy_b; o_dn = dn_b;
      o_sh = sh_b; o_rm = rm_b; o_i20 = i20_b; o_i10 = i10_b; o_i5 = i5_b;
    end else begin
      o_coin = coin_a; o_ej = ej_a; o_bsy = bsy_a; o_dn = dn_a;
      o_sh = sh_a; o_rm = rm_a; o_i20 = i20_a; o_i10 = i10_a; o_i5 = i5_a;
    end
  end

  task automatic check_inv(input string name, input int s);
    tests++;
    if (o_i20 !== 4'(inv[s][0]) || o_i10 !== 4'(inv[s][1]) ||
        o_i5 !== 4'(inv[s][2])) begin
      fails++;
      $display("FAIL %s dut%0d inv got %0d/%0d/%0d want %0d/%0d/%0d",
               name, s, o_i20, o_i10, o_i5, inv[s][0], inv[s][1], inv[s][2]);
    end
  endtask

  // One request: model greedy payout, then compare every cycle to done+1.
  task automatic run_req(input int s, input int c, input int poke);
    int vals[3];
    int coins[$];
    int rem, per, dc, st;
    bit found, bad, exp_ej, exp_bsy, exp_dn;
    logic [1:0] exp_coin;
    vals[0] = 20; vals[1] = 10; vals[2] = 5;
    rem = c;
    do begin
      found = 0;
      for (int d = 0; d < 3; d++) begin
        if (!found && vals[d] <= rem && inv[s][d] > 0) begin
          found = 1;
          coins.push_back(d);
          rem -= vals[d];
          inv[s][d]--;
        end
      end
    end while (found);
    per = pc[s] + gc[s] + 1;
    dc  = 2 + coins.size() * per;
    bad = 0;
    @(negedge clk);
    sel = s; chg = 6'(c); start[s] = 1'b1;
    @(negedge clk);
    start[s] = 1'b0;
    for (int cyc = 1; cyc <= dc + 1; cyc++) begin
      if (cyc > 1) @(negedge clk);
      exp_ej = 0; exp_coin = 2'b00;
      for (int k = 0; k < coins.size(); k++) begin
        st = 2 + k * per;
        if (cyc >= st && cyc < st + pc[s]) begin
          exp_ej = 1; exp_coin = 2'(3 - coins[k]);
        end
      end
      exp_bsy = (cyc <= dc);
      exp_dn  = (cyc == dc);
      if (!bad && {o_ej, o_coin, o_bsy, o_dn} !==
          {exp_ej, exp_coin, exp_bsy, exp_dn}) begin
        bad = 1;
        $display("FAIL trace dut%0d chg=%0d cyc=%0d got ej=%b coin=%b busy=%b done=%b want %b %b %b %b",
                 s, c, cyc, o_ej, o_coin, o_bsy, o_dn,
                 exp_ej, exp_coin, exp_bsy, exp_dn);
      end
      if (cyc == dc) begin
        tests++;
        if (o_sh !== (rem != 0) || o_rm !== 6'(rem)) begin
          fails++;
          $display("FAIL short dut%0d chg=%0d got short=%b rem=%0d want %b %0d",
                   s, c, o_sh, o_rm, rem != 0, rem);
        end
      end
      if (cyc == poke && cyc <= dc) begin
        chg = 6'd20; start[s] = 1'b1;
      end else begin
        start[s] = 1'b0;
      end
    end
    tests++;
    if (bad) fails++;
    check_inv("after_req", s);
  endtask

  task automatic do_refill(input int s, input bit with_start);
    @(negedge clk);
    sel = s; chg = 6'd35; refill[s] = 1'b1; start[s] = with_start;
    @(negedge clk);
    refill[s] = 1'b0; start[s] = 1'b0;
    for (int d = 0; d < 3; d++) inv[s][d] = 8;
    check_inv("refill", s);
    @(negedge clk);
    tests++;
    if (o_bsy !== 1'b0) begin
      fails++;
      $display("FAIL refill_busy dut%0d busy got %b want 0", s, o_bsy);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      tests++;
      if ({o_coin, o_ej, o_bsy, o_dn, o_sh, o_rm} !== 12'd0) begin
        fails++;
        $display("FAIL reset dut%0d outs got %b want 0", s,
                 {o_coin, o_ej, o_bsy, o_dn, o_sh, o_rm});
      end
      check_inv("reset", s);
    end
    @(negedge clk);
    rst = 2'b00;
  endtask

  task automatic test_basic();
    run_req(0, 35, 0);
    run_req(0, 0, 0);
    run_req(0, 7, 0);
  endtask

  task automatic test_drain();
    do_refill(0, 0);
    for (int i = 0; i < 8; i++) run_req(0, 20, 0);
    run_req(0, 40, 0);
    run_req(0, 40, 0);
    run_req(0, 40, 0);
    run_req(0, 15, 0);
  endtask

  task automatic test_busy_ignore();
    do_refill(0, 0);
    run_req(0, 35, 3);
    run_req(0, 5, 1);
    do_refill(0, 1);
  endtask

  task automatic test_reset_mid();
    do_refill(0, 0);
    @(negedge clk);
    sel = 0; chg = 6'd35; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (o_ej !== 1'b1 || o_coin !== 2'b10) begin
      fails++;
      $display("FAIL mid_pulse ej=%b coin=%b want 1 10", o_ej, o_coin);
    end
    rst[0] = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) inv[0][d] = 8;
    tests++;
    if ({o_ej, o_coin, o_bsy, o_dn} !== 5'd0) begin
      fails++;
      $display("FAIL mid_reset outs got %b want 0", {o_ej, o_coin, o_bsy, o_dn});
    end
    check_inv("mid_reset", 0);
    @(negedge clk);
    rst[0] = 1'b0;
    tests++;
    begin
      bit seen = 0;
      repeat (10) begin
        @(negedge clk);
        if (o_ej || o_bsy) seen = 1;
      end
      if (seen) begin
        fails++;
        $display("FAIL post_reset activity got 1 want 0");
      end
    end
  endtask

  task automatic test_slow();
    run_req(1, 35, 0);
    run_req(1, 50, 4);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int s = int'($urandom_range(0, 1));
      if (i % 5 == 0) do_refill(s, 1'($urandom_range(0, 1)));
      run_req(s, int'($urandom_range(0, 63)), int'($urandom_range(0, 4)));
    end
  endtask

  initial begin
    tests = 0; fails = 0; sel = 0;
    pc[0] = 1; gc[0] = 1; pc[1] = 3; gc[1] = 2;
    for (int s = 0; s < 2; s++)
      for (int d = 0; d < 3; d++) inv[s][d] = 8;
    rst = 2'b11; start = 2'b00; refill = 2'b00; chg = 6'd0;
    test_reset();
    test_basic();
    test_drain();
    test_busy_ignore();
    test_reset_mid();
    test_slow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
